// File: rtl/xor_cipher_ctrl_pkg.sv
// rtl/xor_cipher_ctrl_pkg.sv - shared FSM encodings and parameter defaults for the XOR cipher
package xor_cipher_ctrl_pkg;

  localparam int          DEF_DATA_W    = 8;
  localparam int          DEF_KEY_W     = 16;
  localparam int          DEF_CNT_W     = 8;
  localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/xor_ks_lfsr.sv
// rtl/xor_ks_lfsr.sv - Galois LFSR keystream generator with seed load and step enable
module xor_ks_lfsr #(
  parameter int               DATA_W = 8,
  parameter int               KEY_W  = 16,
  parameter logic [KEY_W-1:0] TAPS   = 16'hB400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [KEY_W-1:0]  seed,
  input  logic              step,
  output logic [DATA_W-1:0] ks
);

  logic [KEY_W-1:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= KEY_W'(1);
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= (state >> 1) ^ (state[0] ? TAPS : '0);
    end
  end

  assign ks = state[DATA_W-1:0];

endmodule

// File: rtl/xor_cipher_ctrl.sv
// rtl/xor_cipher_ctrl.sv - one-message XOR cipher sequencer with valid/ready in and out
module xor_cipher_ctrl
  import xor_cipher_ctrl_pkg::*;
#(
  parameter int               DATA_W    = DEF_DATA_W,
  parameter int               KEY_W     = DEF_KEY_W,
  parameter logic [KEY_W-1:0] LFSR_TAPS = KEY_W'(DEF_LFSR_TAPS),
  parameter int               CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [KEY_W-1:0]  seed;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] ks;
  logic              accept;
  logic              drain;
  logic              lfsr_load;

  // A slot opens when the output register is empty or emptying this cycle.
  assign in_ready  = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign lfsr_load = (state == ST_IDLE) && start && (len != '0);
  assign busy      = (state != ST_IDLE);

  xor_ks_lfsr #(
    .DATA_W (DATA_W),
    .KEY_W  (KEY_W),
    .TAPS   (LFSR_TAPS)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed),
    .step (accept),
    .ks   (ks)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      seed      <= KEY_W'(1);
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A zero seed would lock the LFSR at zero forever.
          if (key_load) seed <= (key_in == '0) ? KEY_W'(1) : key_in;
          if (start) begin
            if (len != '0) begin
              state     <= ST_RUN;
              remaining <= len;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data ^ ks;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// tb/tb_xor_cipher_ctrl.sv - randomized self-checking bench for xor_cipher_ctrl
module tb_xor_cipher_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_load = 1'b0;
  logic [15:0] key_in = '0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  xor_cipher_ctrl dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Keystream byte for word n of a message seeded with base.
  function automatic logic [7:0] ks_at(input logic [15:0] base, input int n);
    logic [15:0] s;
    s = base;
    for (int k = 0; k < n; k++) s = lfsr_next(s);
    return s[7:0];
  endfunction

  // Behavioural model: message bookkeeping by word index, not by state machine.
  bit          m_init = 0;
  bit          m_active, m_ov, m_done;
  int          m_left, m_idx;
  logic [15:0] m_seed, m_base, m_old_seed;
  logic [7:0]  m_od;
  bit          m_run, m_acc, m_fire;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_active = 0; m_left = 0; m_idx = 0;
      m_seed = 16'h0001; m_base = 16'h0001; m_ov = 0; m_od = '0; m_done = 0;
    end else begin
      m_run  = m_active && (m_left != 0);
      m_acc  = m_run && in_valid && (!m_ov || out_ready);
      m_fire = m_ov && out_ready;
      m_old_seed = m_seed;
      m_done = 0;
      if (!m_active) begin
        if (key_load) m_seed = (key_in == 16'h0) ? 16'h0001 : key_in;
        if (start) begin
          if (len != 0) begin
            m_active = 1; m_left = int'(len); m_idx = 0; m_base = m_old_seed;
          end else begin
            m_done = 1;
          end
        end
      end else if (!m_run && m_fire) begin
        m_active = 0; m_done = 1;
      end
      if (m_acc) begin
        m_od = in_data ^ ks_at(m_base, m_idx);
        m_idx++; m_left--; m_ov = 1;
      end else if (m_fire) begin
        m_ov = 0;
      end
    end
  end

  logic [7:0] got[$];
  int cyc = 0;
  int first_acc = -1;
  int done_cyc = -1;
  int ov_cycles = 0;

  always @(negedge clk) begin
    if (m_init) begin
      cyc++;
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("done", 32'(done), 32'(m_done));
      check("busy", 32'(busy), 32'(m_active));
      check("in_ready", 32'(in_ready), 32'(m_active && (m_left != 0) && (!m_ov || out_ready)));
      if (m_ov) check("out_data", 32'(out_data), 32'(m_od));
      if (out_valid && out_ready) got.push_back(out_data);
      if (out_valid) ov_cycles++;
      if (in_valid && in_ready && first_acc < 0) first_acc = cyc;
      if (done) done_cyc = cyc;
    end
  end

  logic [7:0] tx[$];
  logic [7:0] plain[$];
  logic [7:0] cipher[$];

  task automatic idle_inputs();
    key_load = 0; start = 0; in_valid = 0; out_ready = 0;
  endtask

  task automatic load_key(input logic [15:0] k);
    key_load = 1; key_in = k;
    @(posedge clk); #1;
    key_load = 0; key_in = 16'($urandom);
  endtask

  task automatic msg(input int n, input int vpct, input int rpct, input int stall_at, input bit poke);
    int i;
    bit fin;
    logic [7:0] held;
    got.delete();
    i = 0; fin = 0; held = '0;
    start = 1; len = n[7:0];
    @(posedge clk); #1;
    start = 0; len = 8'($urandom);
    for (int c = 0; c < 3000 && !fin; c++) begin
      in_valid  = (i < tx.size()) && ($urandom_range(99) < vpct);
      in_data   = in_valid ? tx[i] : 8'($urandom);
      out_ready = ($urandom_range(99) < rpct);
      if (stall_at >= 0 && c >= stall_at && c < stall_at + 5) out_ready = 0;
      key_load = poke && (c == 3);
      start    = poke && (c == 3);
      key_in   = 16'($urandom);
      len      = 8'($urandom_range(1, 255));
      @(negedge clk);
      if (stall_at >= 0 && c == stall_at) held = out_data;
      if (stall_at >= 0 && c >= stall_at && c < stall_at + 5) begin
        check("bp_out_data_stable", 32'(out_data), 32'(held));
        check("bp_in_ready_low", 32'(in_ready), 32'h0);
      end
      if (in_valid && in_ready) i++;
      if (done) fin = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL msg_timeout: got no done expected done within 3000 cycles");
    end
    idle_inputs();
  endtask

  task automatic check_abc(input string name);
    check({name, "_count"}, 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check({name, "_w0"}, 32'(got[0]), 32'h40);
      check({name, "_w1"}, 32'(got[1]), 32'h42);
      check({name, "_w2"}, 32'(got[2]), 32'h43);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_out_data", 32'(out_data), 32'h0);
    check("model_step_pin", 32'(lfsr_next(16'h0001)), 32'hB400);
    @(posedge clk); #1;

    // 1: basic message with seed 1
    load_key(16'h0001);
    tx = '{8'h41, 8'h42, 8'h43};
    msg(3, 100, 100, -1, 0);
    check_abc("s1");
    @(negedge clk);
    check("s1_busy_after", 32'(busy), 32'h0);
    @(posedge clk); #1;

    // 2: round trip
    plain.delete();
    for (int k = 0; k < 16; k++) plain.push_back(8'($urandom));
    load_key(16'hACE1);
    tx = plain;
    msg(16, 70, 70, -1, 0);
    cipher = got;
    load_key(16'hACE1);
    tx = cipher;
    msg(16, 70, 70, -1, 0);
    check("rt_count", 32'(got.size()), 32'd16);
    if (got.size() == 16)
      for (int k = 0; k < 16; k++) check("rt_word", 32'(got[k]), 32'(plain[k]));

    // 3: backpressure mid-message
    tx.delete();
    for (int k = 0; k < 8; k++) tx.push_back(8'($urandom));
    msg(8, 100, 100, 2, 0);
    check("bp_count", 32'(got.size()), 32'd8);

    // 4: key 0, zero-length, and ignored pokes while running
    load_key(16'h0000);
    tx = '{8'h41, 8'h42, 8'h43};
    msg(3, 100, 100, -1, 0);
    check_abc("k0");
    tx.delete();
    msg(0, 100, 100, -1, 0);
    check("len0_count", 32'(got.size()), 32'd0);
    tx.delete();
    for (int k = 0; k < 10; k++) tx.push_back(8'($urandom));
    msg(10, 100, 100, -1, 1);
    check("poke_count", 32'(got.size()), 32'd10);

    // 5: reset mid-message with a word pending
    load_key(16'hACE1);
    start = 1; len = 8'd3;
    @(posedge clk); #1;
    start = 0; in_valid = 1; in_data = 8'h55; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("rst_pre_out_valid", 32'(out_valid), 32'h1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    tx = '{8'h41, 8'h42, 8'h43};
    msg(3, 100, 100, -1, 0);
    check_abc("rst_seed1");

    // 6: full throughput
    tx.delete();
    for (int k = 0; k < 255; k++) tx.push_back(8'($urandom));
    first_acc = -1; done_cyc = -1; ov_cycles = 0;
    msg(255, 100, 100, -1, 0);
    check("tp_count", 32'(got.size()), 32'd255);
    check("tp_valid_cycles", 32'(ov_cycles), 32'd255);
    check("tp_done_offset", 32'(done_cyc - first_acc), 32'd256);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
